// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM port arbiter.
// Access FSM states, grant owner and counter sizing helper.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_e;

   typedef enum logic {
      GNT_WR,
      GNT_RD
   } arb_grant_e;

   // Width of a counter that must reach max_val, never below 8 bits.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/sdram_req_slot.sv
// sdram_req_slot: one-entry request capture register.
// Ports: cap/cap_data load an entry, free empties it, valid/data
// expose the held entry. With OVERWRITE=0 a capture into a full
// slot that is not being freed this cycle is ignored.
module sdram_req_slot
#(
   parameter int W         = 8,
   parameter bit OVERWRITE = 1'b0
)
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cap,
   input  logic [W-1:0] cap_data,
   input  logic         free,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // A capture in the same cycle as a free wins: the old entry has
   // already been copied out, the new one takes its place.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (free) begin
         valid_d = 1'b0;
      end
      if (cap && (OVERWRITE || !valid_q || free)) begin
         valid_d = 1'b1;
         data_d  = cap_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between the
// loader (ld_*, buffered writes) and the cassette player (cas_*,
// queued reads). mem_* drive the controller; wr_overflow and
// mem_timeout are sticky error flags cleared only by reset.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW           = 25,
   parameter int DW           = 8,
   parameter int MAX_WR_BURST = 4,
   parameter int TIMEOUT      = 255
)
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          cas_rd,
   input  logic [AW-1:0] cas_addr,
   output logic [DW-1:0] cas_data,
   output logic          cas_valid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_ready,
   output logic          wr_overflow,
   output logic          mem_timeout
);

   localparam int TW = cnt_width(TIMEOUT);
   localparam int BW = $clog2(MAX_WR_BURST + 1);

   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

   // Request slots
   logic          wr_valid;
   logic          wr_free;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_free;
   logic [AW-1:0] rd_addr;

   sdram_req_slot #(
      .W         (AW + DW),
      .OVERWRITE (1'b0)
   ) u_wr_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .cap      (ld_wr),
      .cap_data ({ld_addr, ld_data}),
      .free     (wr_free),
      .valid    (wr_valid),
      .data     ({wr_addr, wr_data})
   );

   // Latest cassette address wins while still queued.
   sdram_req_slot #(
      .W         (AW),
      .OVERWRITE (1'b1)
   ) u_rd_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .cap      (cas_rd),
      .cap_data (cas_addr),
      .free     (rd_free),
      .valid    (rd_valid),
      .data     (rd_addr)
   );

   // State
   arb_state_e    state_q;
   arb_state_e    state_d;
   arb_grant_e    grant_q;
   arb_grant_e    grant_d;
   logic [BW-1:0] burst_q;
   logic [BW-1:0] burst_d;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;
   logic [AW-1:0] mem_addr_q;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_din_q;
   logic [DW-1:0] mem_din_d;
   logic [DW-1:0] cas_data_q;
   logic [DW-1:0] cas_data_d;
   logic          ovf_q;
   logic          ovf_d;
   logic          tmo_flag_q;
   logic          tmo_flag_d;

   logic pick_rd;

   // Reads are held off only while a write is waiting and the
   // write burst has not yet reached its limit.
   assign pick_rd = rd_valid &&
                    (!wr_valid || (burst_q == BURST_MAX));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      burst_d    = burst_q;
      tmo_d      = tmo_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      cas_data_d = cas_data_q;
      tmo_flag_d = tmo_flag_q;
      wr_free    = 1'b0;
      rd_free    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The entry is copied into the mem_* registers here and
            // the slot is released, so new requests can queue behind.
            if (wr_valid || rd_valid) begin
               state_d = ISSUE;
               if (pick_rd) begin
                  grant_d    = GNT_RD;
                  mem_addr_d = rd_addr;
                  rd_free    = 1'b1;
               end else begin
                  grant_d    = GNT_WR;
                  mem_addr_d = wr_addr;
                  mem_din_d  = wr_data;
                  wr_free    = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            tmo_d   = '0;
         end
         WAIT: begin
            if (mem_ready) begin
               state_d = DONE;
               if (grant_q == GNT_RD) begin
                  cas_data_d = mem_dout;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d    = IDLE;
               tmo_flag_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Burst counts writes granted over a waiting read.
      if (!rd_valid) begin
         burst_d = '0;
      end else if (rd_free) begin
         burst_d = '0;
      end else if (wr_free && (burst_q != BURST_MAX)) begin
         burst_d = burst_q + BW'(1);
      end

      ovf_d = ovf_q | (ld_wr && wr_valid && !wr_free);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= GNT_WR;
         burst_q    <= '0;
         tmo_q      <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         cas_data_q <= '0;
         ovf_q      <= 1'b0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         burst_q    <= burst_d;
         tmo_q      <= tmo_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         cas_data_q <= cas_data_d;
         ovf_q      <= ovf_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign mem_we      = (state_q == ISSUE) && (grant_q == GNT_WR);
   assign mem_rd      = (state_q == ISSUE) && (grant_q == GNT_RD);
   assign cas_valid   = (state_q == DONE) && (grant_q == GNT_RD);
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign cas_data    = cas_data_q;
   assign wr_overflow = ovf_q;
   assign mem_timeout = tmo_flag_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_sdram_port_arbiter;

   localparam int AW   = 25;
   localparam int DW   = 8;
   localparam int MAXB = 4;
   localparam int TMO  = 255;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ld_wr = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          cas_rd = 1'b0;
   logic [AW-1:0] cas_addr = '0;
   logic [DW-1:0] cas_data;
   logic          cas_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic          mem_rd;
   logic [DW-1:0] mem_dout = '0;
   logic          mem_ready = 1'b0;
   logic          wr_overflow;
   logic          mem_timeout;

   int total = 0;
   int bad = 0;

   sdram_port_arbiter #(
      .AW           (AW),
      .DW           (DW),
      .MAX_WR_BURST (MAXB),
      .TIMEOUT      (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ld_wr       (ld_wr),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .cas_rd      (cas_rd),
      .cas_addr    (cas_addr),
      .cas_data    (cas_data),
      .cas_valid   (cas_valid),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_dout    (mem_dout),
      .mem_ready   (mem_ready),
      .wr_overflow (wr_overflow),
      .mem_timeout (mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Controller stand-in: ready lat cycles after a command
   // (lat 0 = never), optional stray ready pulses in random mode.
   bit            rmode = 1'b0;
   int            lat_cfg = 3;
   logic [DW-1:0] rd_cfg = '0;
   int            rcnt = 0;

   initial forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_dout  = rmode ? DW'($urandom) : rd_cfg;
      if (rcnt > 0) begin
         rcnt--;
         if (rcnt == 0) mem_ready = 1'b1;
      end else if (rmode && $urandom_range(0, 19) == 0) begin
         mem_ready = 1'b1;
      end
      if (mem_we || mem_rd) begin
         if (rmode)
            rcnt = ($urandom_range(0, 63) == 0) ? 0 :
                   int'($urandom_range(1, 7));
         else
            rcnt = lat_cfg;
      end
   end

   // Reference model: pending write, pending read, one access in
   // flight described by its age since issue.
   bit            m_wbv, m_rqv, m_busy, m_done, m_acc_rd;
   logic [AW-1:0] m_wba, m_rqa, m_addr;
   logic [DW-1:0] m_wbd, m_din, m_cdata;
   int            m_age, m_streak;
   bit            m_wovf, m_tmo;

   task automatic model_reset();
      m_wbv = 0; m_rqv = 0; m_busy = 0; m_done = 0; m_acc_rd = 0;
      m_wba = '0; m_rqa = '0; m_addr = '0;
      m_wbd = '0; m_din = '0; m_cdata = '0;
      m_age = 0; m_streak = 0; m_wovf = 0; m_tmo = 0;
   endtask

   task automatic model_step();
      bit rq_pre;
      rq_pre = m_rqv;
      if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         if (m_age == 0) begin
            m_age = 1;
         end else if (mem_ready) begin
            m_busy = 0;
            m_done = 1;
            if (m_acc_rd) m_cdata = mem_dout;
         end else if (m_age == TMO) begin
            m_busy = 0;
            m_tmo = 1;
         end else begin
            m_age++;
         end
      end else if (m_wbv || m_rqv) begin
         m_acc_rd = m_rqv && (!m_wbv || m_streak == MAXB);
         m_busy = 1;
         m_age = 0;
         if (m_acc_rd) begin
            m_addr = m_rqa;
            m_rqv = 0;
            m_streak = 0;
         end else begin
            m_addr = m_wba;
            m_din = m_wbd;
            m_wbv = 0;
            if (rq_pre && m_streak < MAXB) m_streak++;
         end
      end
      if (!rq_pre) m_streak = 0;
      if (ld_wr) begin
         if (!m_wbv) begin
            m_wbv = 1;
            m_wba = ld_addr;
            m_wbd = ld_data;
         end else begin
            m_wovf = 1;
         end
      end
      if (cas_rd) begin
         m_rqv = 1;
         m_rqa = cas_addr;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   int n_we = 0;
   int n_rd = 0;
   int n_cv = 0;

   task automatic compare();
      chk("mem_we", mem_we, m_busy && m_age == 0 && !m_acc_rd);
      chk("mem_rd", mem_rd, m_busy && m_age == 0 && m_acc_rd);
      chk("cas_valid", cas_valid, m_done && m_acc_rd);
      chk("cas_data", cas_data, m_cdata);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_din", mem_din, m_din);
      chk("wr_overflow", wr_overflow, m_wovf);
      chk("mem_timeout", mem_timeout, m_tmo);
      if (mem_we) n_we++;
      if (mem_rd) n_rd++;
      if (cas_valid) n_cv++;
   endtask

   initial forever begin
      @(negedge clk);
      compare();
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int  w0, c0, lt, k, nw;
      bit  found, prev_rdy, rd_seen;

      repeat (3) cyc();
      chk("rst_we_rd_cv", {mem_we, mem_rd, cas_valid}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_din_data", {mem_din, cas_data}, 0);
      chk("rst_flags", {wr_overflow, mem_timeout}, 0);
      #1 reset_n = 1'b1;
      cyc();

      // Single write
      lat_cfg = 3;
      w0 = n_we;
      ld_wr = 1; ld_addr = 25'h000100; ld_data = 8'hA5;
      found = 0; lt = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         cyc();
         ld_wr = 0;
         if (mem_we) begin
            found = 1;
            lt = i;
            chk("wr_addr", mem_addr, 25'h000100);
            chk("wr_din", mem_din, 8'hA5);
         end
      end
      chk("wr_seen", found, 1);
      chk("wr_latency", lt, 2);
      repeat (8) cyc();
      chk("wr_count", n_we - w0, 1);
      chk("wr_flags", {wr_overflow, mem_timeout}, 0);

      // Single read
      rd_cfg = 8'h3C;
      c0 = n_cv;
      cas_rd = 1; cas_addr = 25'h000200;
      found = 0; prev_rdy = 0;
      for (int i = 1; i <= 15 && !found; i++) begin
         cyc();
         cas_rd = 0;
         if (mem_rd) chk("rd_addr", mem_addr, 25'h000200);
         if (cas_valid) begin
            found = 1;
            chk("rd_data", cas_data, 8'h3C);
            chk("rd_after_ready", prev_rdy, 1);
         end
         prev_rdy = mem_ready;
      end
      chk("rd_seen", found, 1);
      repeat (4) cyc();
      chk("rd_cv_count", n_cv - c0, 1);
      chk("rd_hold", cas_data, 8'h3C);

      // Starvation: read waits for exactly MAXB writes
      nw = 0; rd_seen = 0;
      for (int c = 0; c < 45; c++) begin
         ld_wr = (c % 6 == 0) && (c < 30);
         ld_addr = AW'(32'h1000 + c);
         ld_data = DW'(c);
         cas_rd = (c == 0);
         cas_addr = 25'h002000;
         cyc();
         if (mem_rd && !rd_seen) rd_seen = 1;
         if (mem_we && !rd_seen) nw++;
      end
      ld_wr = 0; cas_rd = 0;
      chk("starve_rd_seen", rd_seen, 1);
      chk("starve_writes", nw, MAXB);
      repeat (10) cyc();
      chk("starve_no_ovf", wr_overflow, 0);

      // Overflow while the controller stalls
      lat_cfg = 20;
      ld_wr = 1; ld_addr = 25'h000300; ld_data = 8'h11;
      cyc();
      ld_wr = 0;
      repeat (4) cyc();
      ld_wr = 1; ld_addr = 25'h000301; ld_data = 8'h22;
      cyc();
      ld_addr = 25'h000302; ld_data = 8'h33;
      cyc();
      ld_wr = 0;
      cyc();
      chk("ovf_flag", wr_overflow, 1);
      w0 = n_we; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc();
         if (mem_we) begin
            found = 1;
            chk("ovf_kept_addr", mem_addr, 25'h000301);
            chk("ovf_kept_din", mem_din, 8'h22);
         end
      end
      chk("ovf_wr_seen", found, 1);
      repeat (30) cyc();
      chk("ovf_wr_count", n_we - w0, 1);

      // Timeout on a read
      lat_cfg = 0;
      c0 = n_cv;
      cas_rd = 1; cas_addr = 25'h000400;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         cyc();
         cas_rd = 0;
         if (mem_rd) found = 1;
      end
      chk("tmo_rd_seen", found, 1);
      k = 0;
      while (!mem_timeout && k < 300) begin
         cyc();
         k++;
      end
      chk("tmo_cycles", k, TMO + 1);
      chk("tmo_flag", mem_timeout, 1);
      chk("tmo_no_cv", n_cv - c0, 0);
      lat_cfg = 2;
      ld_wr = 1; ld_addr = 25'h000410; ld_data = 8'h7E;
      found = 0; lt = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         cyc();
         ld_wr = 0;
         if (mem_we) begin
            found = 1;
            lt = i;
         end
      end
      chk("tmo_idle_latency", lt, 2);
      repeat (6) cyc();
      chk("tmo_sticky", mem_timeout, 1);

      // Reset in the middle of WAIT
      lat_cfg = 5;
      ld_wr = 1; ld_addr = 25'h000500; ld_data = 8'h55;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         cyc();
         ld_wr = 0;
         if (mem_we) found = 1;
      end
      chk("rstw_we_seen", found, 1);
      cyc();
      #1 reset_n = 1'b0;
      #1;
      chk("rstw_strobes", {mem_we, mem_rd, cas_valid}, 0);
      chk("rstw_addr", mem_addr, 0);
      chk("rstw_din_data", {mem_din, cas_data}, 0);
      chk("rstw_flags", {wr_overflow, mem_timeout}, 0);
      cyc();
      cyc();
      #1 reset_n = 1'b1;
      w0 = n_we; c0 = n_cv; k = n_rd;
      repeat (10) cyc();
      chk("rstw_quiet", {n_we - w0, n_cv - c0, n_rd - k}, 0);
      chk("rstw_addr_after", mem_addr, 0);

      // Random traffic
      rmode = 1;
      repeat (3000) begin
         ld_wr = ($urandom_range(0, 3) == 0);
         ld_addr = AW'($urandom);
         ld_data = DW'($urandom);
         cas_rd = ($urandom_range(0, 4) == 0);
         cas_addr = AW'($urandom);
         cyc();
      end
      ld_wr = 0; cas_rd = 0;
      repeat (300) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
